imsic_msi_ingress: RTL and testbench
====================================

# imsic_msi_ingress

Buffered MSI ingress stage for the IMSIC, generalised to any hart count, interrupt-file count and queue depth. It accepts 32-bit MMIO writes on a simple valid/ready channel, decodes the target hart/file from the M- and S-level interrupt-file windows, and supports both SETEIPNUM_LE and SETEIPNUM_BE. It validates the identity and queues accepted MSIs in a FIFO. A valid/ready stream drains the FIFO toward the interrupt-file array. Rejected writes are counted.

## Interface
- NrHarts, 4: harts served, ≥1.
- NrFiles, 3: interrupt files per hart (file 0 = M, 1..NrFiles-1 = S/VS), ≥2.
- NrSources, 256: identities; valid IDs are 1..NrSources-1.
- MBaseAddr, 32'h2400_0000: base of the M-file window, 4 KiB per hart.
- SBaseAddr, 32'h2800_0000: base of the S-file window, 4 KiB per (hart, file≥1).
- FifoDepth, 4: queue entries; power of two, ≥2.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_wr_valid  in  1  write request valid.
- o_wr_ready  out  1  write request accepted this cycle when high with i_wr_valid.
- i_wr_addr  in  32  byte address.
- i_wr_data  in  32  write data.
- i_wr_be  in  4  byte enables.
- o_msi_valid  out  1  queued MSI available.
- i_msi_ready  in  1  consumer takes the head entry.
- o_msi_hart  out  $clog2(NrHarts) (min 1)  target hart.
- o_msi_file  out  $clog2(NrFiles)  target file.
- o_msi_id  out  $clog2(NrSources)  identity.
- o_drop_cnt  out  16  saturating count of accepted-but-rejected writes.
- o_fifo_level  out  $clog2(FifoDepth)+1  current occupancy.

## Operation
- o_wr_ready = !full. A handshake (i_wr_valid & o_wr_ready) always consumes the write. The write is then either pushed or dropped.
- M window: MBaseAddr ≤ addr < MBaseAddr + NrHarts·0x1000. page = (addr−MBaseAddr)>>12. hart = page. file = 0.
- S window: SBaseAddr ≤ addr < SBaseAddr + NrHarts·(NrFiles−1)·0x1000. page = (addr−SBaseAddr)>>12. hart = page/(NrFiles−1). file = page%(NrFiles−1)+1.
- Page offset addr[11:0]: 0x000 selects LE, where raw = data. 0x004 selects BE, where raw = byte-reversed data.
- ID = raw truncated to the ID width. The ID is valid only if raw[31:0] ≥ 1 and raw[31:0] < NrSources; upper bits must be zero.
- A write is pushed only if all of the following hold:
  - the address is in a window;
  - the offset is legal;
  - i_wr_be == 4'hF;
  - the ID is valid.
- Any other handshaken write is dropped, and o_drop_cnt increments, saturating at 16'hFFFF.
- Pop on o_msi_valid & i_msi_ready.
- Windows that overlap are a configuration error; the M window wins.

## Timing
- Reset values: o_wr_ready=0 during the reset cycle, then 1; o_msi_valid=0; ID/hart/file=0; o_drop_cnt=0; o_fifo_level=0. Pointers and count are cleared.
- Reset mid-operation flushes every queued entry. No entry survives reset.
- Latency: a write handshaken in cycle N is visible on o_msi_valid in N+1 (registered, no fall-through).
- o_msi_* outputs are stable while o_msi_valid & !i_msi_ready.
- Full: o_wr_ready=0, even if a pop occurs in the same cycle (no same-cycle pass-through). Ready returns the cycle after the level drops.
- Simultaneous push and pop when not full and not empty: the level is unchanged and both pointers advance.
- Empty with a push: the level goes to 1 next cycle.
- Pointers wrap modulo FifoDepth. The level distinguishes full from empty.

## Configuration
- IMSIC_SETIPNUM_BE_EN
  - Defined: offset 0x004 (BE) is decoded as above.
  - Undefined: offset 0x004 is illegal; such writes are dropped and counted. The byte-reversal logic is absent.

## Structure
- imsic_pkg carries the following, and the block uses them:
  - imsic_msi_t struct {hart, file, id};
  - IMSIC_PAGE_W = 12;
  - IMSIC_SETEIPNUM_LE_OFF = 12'h000;
  - IMSIC_SETEIPNUM_BE_OFF = 12'h004.
- Sub-module imsic_msi_fifo: generic synchronous FIFO parametrised by depth and entry type, with push/pop/full/empty/level.
- Decode and drop counting stay in the top.

## Test plan
- LE write 32'h0000_0005 to MBaseAddr+0x1000, be=F -> next cycle msi_valid with hart=1, file=0, id=5; drop_cnt=0.
- BE write 32'h0700_0000 to SBaseAddr+0x3004 with NrFiles=3 (macro on) -> hart=1, file=2, id=7. With the macro off -> no push, drop_cnt=1.
- IDs 0, 256, and 32'h1_0001 to the M window, plus be=4'h3 with id 5 -> four drops; drop_cnt=4; msi_valid stays 0.
- Hold i_msi_ready=0 and push 5 valid writes with FifoDepth=4 -> wr_ready low after the 4th; level=4. Pop once -> the 5th is accepted one cycle later; order is preserved.
- Push and pop in the same cycle at level 2 -> level stays 2 over 8 cycles, and pointers wrap correctly.
- Assert i_rst with level 3 -> next cycle msi_valid=0, level=0, drop_cnt=0; the first post-reset write emerges alone.

Source files
------------

// File: rtl/imsic_pkg.sv
// Shared types and constants for the IMSIC MSI ingress path.
// Struct fields are sized for the largest supported configuration; each
// block uses only the low bits its own parameters call for.
package imsic_pkg;

   localparam int IMSIC_PAGE_W    = 12;
   localparam int IMSIC_PAGE_SIZE = 1 << IMSIC_PAGE_W;

   localparam logic [IMSIC_PAGE_W-1:0] IMSIC_SETEIPNUM_LE_OFF = 12'h000;
   localparam logic [IMSIC_PAGE_W-1:0] IMSIC_SETEIPNUM_BE_OFF = 12'h004;

   localparam int IMSIC_HART_MAX_W = 14;
   localparam int IMSIC_FILE_MAX_W = 6;
   localparam int IMSIC_ID_MAX_W   = 11;

   typedef struct packed {
      logic [IMSIC_HART_MAX_W-1:0] hart;
      logic [IMSIC_FILE_MAX_W-1:0] file;
      logic [IMSIC_ID_MAX_W-1:0]   id;
   } imsic_msi_t;

   // Big-endian SETEIPNUM stores the identity with its bytes reversed.
   function automatic logic [31:0] imsic_byte_swap(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Generic synchronous FIFO, registered output, no fall-through.
// Depth must be a power of two so pointers wrap for free; the level
// counter tells full from empty when the pointers are equal.
module imsic_msi_fifo #(
   parameter int  Depth   = 4,
   parameter type entry_t = logic [7:0],
   localparam int PtrW    = $clog2(Depth)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  entry_t        i_push_data,
   input  logic          i_pop,
   output entry_t        o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [PtrW:0] o_level
);

   localparam logic [PtrW:0] FULL_LEVEL = (PtrW+1)'(Depth);

   entry_t          mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW:0]   level;
   logic            do_push;
   logic            do_pop;

   assign o_full  = (level == FULL_LEVEL);
   assign o_empty = (level == '0);
   assign o_level = level;
   assign o_head  = mem[rd_ptr];
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // Storage array; contents need no reset since the level gates validity.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/imsic_msi_ingress.sv
// Buffered MSI ingress: decodes SETEIPNUM writes in the M and S
// interrupt-file windows, validates the identity, queues accepted MSIs
// and counts rejected writes.
// Optional feature macro: IMSIC_SETIPNUM_BE_EN enables the big-endian
// SETEIPNUM register at page offset 0x004; without it that offset drops.
// Window bases are expected to be 4 KiB aligned. If the windows overlap,
// the M window takes priority.
module imsic_msi_ingress
   import imsic_pkg::*;
#(
   parameter int          NrHarts   = 4,
   parameter int          NrFiles   = 3,
   parameter int          NrSources = 256,
   parameter logic [31:0] MBaseAddr = 32'h2400_0000,
   parameter logic [31:0] SBaseAddr = 32'h2800_0000,
   parameter int          FifoDepth = 4,
   localparam int         HartW     = (NrHarts > 1) ? $clog2(NrHarts) : 1,
   localparam int         FileW     = $clog2(NrFiles),
   localparam int         IdW       = $clog2(NrSources),
   localparam int         LevelW    = $clog2(FifoDepth) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [31:0]       i_wr_addr,
   input  logic [31:0]       i_wr_data,
   input  logic [3:0]        i_wr_be,
   output logic              o_msi_valid,
   input  logic              i_msi_ready,
   output logic [HartW-1:0]  o_msi_hart,
   output logic [FileW-1:0]  o_msi_file,
   output logic [IdW-1:0]    o_msi_id,
   output logic [15:0]       o_drop_cnt,
   output logic [LevelW-1:0] o_fifo_level
);

   localparam int PageNumW = 32 - IMSIC_PAGE_W;
   localparam int SFiles   = NrFiles - 1;

   localparam logic [32:0] M_LO = {1'b0, MBaseAddr};
   localparam logic [32:0] M_HI = M_LO + 33'(NrHarts) * 33'(IMSIC_PAGE_SIZE);
   localparam logic [32:0] S_LO = {1'b0, SBaseAddr};
   localparam logic [32:0] S_HI = S_LO + 33'(NrHarts * SFiles) * 33'(IMSIC_PAGE_SIZE);

   logic [32:0]         addr_ext;
   logic                in_m;
   logic                in_s;
   logic [PageNumW-1:0] page_m;
   logic [PageNumW-1:0] page_s;
   logic                off_ok;
   logic [31:0]         raw;
   logic                id_ok;
   logic                wr_hs;
   logic                push;
   logic                drop;
   imsic_msi_t          msi_in;
   imsic_msi_t          msi_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                unused_head;

   assign addr_ext = {1'b0, i_wr_addr};
   assign in_m     = (addr_ext >= M_LO) && (addr_ext < M_HI);
   assign in_s     = (addr_ext >= S_LO) && (addr_ext < S_HI);
   assign page_m   = i_wr_addr[31:IMSIC_PAGE_W] - MBaseAddr[31:IMSIC_PAGE_W];
   assign page_s   = i_wr_addr[31:IMSIC_PAGE_W] - SBaseAddr[31:IMSIC_PAGE_W];

   // Page-offset decode selects the endianness of the identity.
   always_comb begin
      off_ok = 1'b0;
      raw    = i_wr_data;
      if (i_wr_addr[IMSIC_PAGE_W-1:0] == IMSIC_SETEIPNUM_LE_OFF) begin
         off_ok = 1'b1;
      end
`ifdef IMSIC_SETIPNUM_BE_EN
      else if (i_wr_addr[IMSIC_PAGE_W-1:0] == IMSIC_SETEIPNUM_BE_OFF) begin
         off_ok = 1'b1;
         raw    = imsic_byte_swap(i_wr_data);
      end
`endif
   end

   // Full 32-bit compare so any stray upper bit invalidates the identity.
   assign id_ok = (raw != 32'd0) && (raw < 32'(NrSources));

   // Target hart/file from whichever window matched; M wins on overlap.
   always_comb begin
      msi_in    = '0;
      msi_in.id = IMSIC_ID_MAX_W'(raw);
      if (in_m) begin
         msi_in.hart = IMSIC_HART_MAX_W'(page_m);
         msi_in.file = '0;
      end else if (in_s) begin
         msi_in.hart = IMSIC_HART_MAX_W'(page_s / PageNumW'(SFiles));
         msi_in.file = IMSIC_FILE_MAX_W'(page_s % PageNumW'(SFiles)) + IMSIC_FILE_MAX_W'(1);
      end
   end

   assign o_wr_ready = !fifo_full && !i_rst;
   assign wr_hs      = i_wr_valid && o_wr_ready;
   assign push       = wr_hs && (in_m || in_s) && off_ok && (i_wr_be == 4'hF) && id_ok;
   assign drop       = wr_hs && !push;

   imsic_msi_fifo #(
      .Depth   (FifoDepth),
      .entry_t (imsic_msi_t)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push),
      .i_push_data (msi_in),
      .i_pop       (o_msi_valid && i_msi_ready),
      .o_head      (msi_head),
      .o_full      (fifo_full),
      .o_empty     (fifo_empty),
      .o_level     (o_fifo_level)
   );

   // Head fields are forced to zero while nothing valid is queued.
   assign o_msi_valid = !fifo_empty && !i_rst;
   assign o_msi_hart  = o_msi_valid ? msi_head.hart[HartW-1:0] : '0;
   assign o_msi_file  = o_msi_valid ? msi_head.file[FileW-1:0] : '0;
   assign o_msi_id    = o_msi_valid ? msi_head.id[IdW-1:0]     : '0;
   assign unused_head = ^msi_head;

   // Saturating count of handshaken writes that were not queued.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_drop_cnt <= '0;
      end else if (drop && (o_drop_cnt != 16'hFFFF)) begin
         o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_imsic_msi_ingress.sv
// Bench for imsic_msi_ingress: table of single writes with hand-derived
// targets, then multi-cycle full / streaming / reset sequences. Queued
// MSIs are matched in order against a scoreboard queue.
`timescale 1ns/1ps
module tb_imsic_msi_ingress;

   localparam logic [31:0] MB = 32'h2400_0000;
   localparam logic [31:0] SB = 32'h2800_0000;
`ifdef IMSIC_SETIPNUM_BE_EN
   localparam bit BE_ON = 1'b1;
`else
   localparam bit BE_ON = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_wr_valid;
   logic        o_wr_ready;
   logic [31:0] i_wr_addr;
   logic [31:0] i_wr_data;
   logic [3:0]  i_wr_be;
   logic        o_msi_valid;
   logic        i_msi_ready;
   logic [1:0]  o_msi_hart;
   logic [1:0]  o_msi_file;
   logic [7:0]  o_msi_id;
   logic [15:0] o_drop_cnt;
   logic [2:0]  o_fifo_level;

   always #5 i_clk = ~i_clk;

   imsic_msi_ingress #(
      .NrHarts   (4),
      .NrFiles   (3),
      .NrSources (256),
      .MBaseAddr (MB),
      .SBaseAddr (SB),
      .FifoDepth (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wr_valid   (i_wr_valid),
      .o_wr_ready   (o_wr_ready),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .i_wr_be      (i_wr_be),
      .o_msi_valid  (o_msi_valid),
      .i_msi_ready  (i_msi_ready),
      .o_msi_hart   (o_msi_hart),
      .o_msi_file   (o_msi_file),
      .o_msi_id     (o_msi_id),
      .o_drop_cnt   (o_drop_cnt),
      .o_fifo_level (o_fifo_level)
   );

   typedef struct packed {
      logic [1:0] hart;
      logic [1:0] file;
      logic [7:0] id;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      bit          push;
      exp_t        e;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[17];
   int   total = 0;
   int   bad = 0;
   int   exp_drop = 0;
   int   pops = 0;
   int   pops_before;

   function automatic exp_t mk(input int h, input int f, input int id);
      exp_t r;
      r.hart = 2'(h);
      r.file = 2'(f);
      r.id   = 8'(id);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drive one write from posedge+1; returns at posedge+1 after its handshake.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input bit exp_push, input exp_t e);
      int n;
      i_wr_addr  = a;
      i_wr_data  = d;
      i_wr_be    = be;
      i_wr_valid = 1'b1;
      n = 0;
      @(negedge i_clk);
      while (!o_wr_ready && n < 50) begin
         n++;
         @(negedge i_clk);
      end
      if (!o_wr_ready) begin
         total++;
         bad++;
         $display("FAIL wr_timeout: wr_ready=0 after 50 cycles, required 1");
         i_wr_valid = 1'b0;
         tick();
         return;
      end
      if (exp_push) sb_q.push_back(e);
      else          exp_drop++;
      tick();
      i_wr_valid = 1'b0;
   endtask

   // Output monitor: compares every popped entry against the scoreboard.
   always @(negedge i_clk) begin
      if (i_rst) begin
         sb_q.delete();
      end else if (o_msi_valid) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: got id=%0d, required no entry", o_msi_id);
         end else if (i_msi_ready) begin
            mon_e = sb_q.pop_front();
            check("pop_hart", 32'(o_msi_hart), 32'(mon_e.hart));
            check("pop_file", 32'(o_msi_file), 32'(mon_e.file));
            check("pop_id",   32'(o_msi_id),   32'(mon_e.id));
            pops++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{MB + 32'h1000, 32'h0000_0005, 4'hF, 1'b1,  mk(1, 0, 5)};
      vecs[1]  = '{SB + 32'h3004, 32'h0700_0000, 4'hF, BE_ON, mk(1, 2, 7)};
      vecs[2]  = '{MB,            32'h0000_0000, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[3]  = '{MB,            32'h0000_0100, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[4]  = '{MB,            32'h0001_0001, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[5]  = '{MB,            32'h0000_0005, 4'h3, 1'b0,  mk(0, 0, 0)};
      vecs[6]  = '{MB + 32'h3000, 32'h0000_00FF, 4'hF, 1'b1,  mk(3, 0, 255)};
      vecs[7]  = '{SB,            32'h0000_0001, 4'hF, 1'b1,  mk(0, 1, 1)};
      vecs[8]  = '{SB + 32'h7000, 32'h0000_0009, 4'hF, 1'b1,  mk(3, 2, 9)};
      vecs[9]  = '{SB + 32'h8000, 32'h0000_0009, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[10] = '{MB + 32'h4000, 32'h0000_0009, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[11] = '{MB + 32'h1008, 32'h0000_0009, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[12] = '{MB - 32'h1000, 32'h0000_0009, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[13] = '{MB + 32'h2004, 32'h0B00_0000, 4'hF, BE_ON, mk(2, 0, 11)};
      vecs[14] = '{MB + 32'h0004, 32'h0000_0005, 4'hF, 1'b0,  mk(0, 0, 0)};
      vecs[15] = '{SB + 32'h5000, 32'h0000_0003, 4'hF, 1'b1,  mk(2, 2, 3)};
      vecs[16] = '{SB + 32'h4000, 32'h0000_00C8, 4'hF, 1'b1,  mk(2, 1, 200)};

      i_rst       = 1'b1;
      i_wr_valid  = 1'b0;
      i_wr_addr   = '0;
      i_wr_data   = '0;
      i_wr_be     = '0;
      i_msi_ready = 1'b0;

      // Reset state
      @(negedge i_clk);
      check("rst_wr_ready", 32'(o_wr_ready), 0);
      tick();
      tick();
      i_rst = 1'b0;
      @(negedge i_clk);
      check("init_wr_ready", 32'(o_wr_ready), 1);
      check("init_valid",    32'(o_msi_valid), 0);
      check("init_level",    32'(o_fifo_level), 0);
      check("init_drop",     32'(o_drop_cnt), 0);
      check("init_id",       32'(o_msi_id), 0);
      check("init_hart",     32'(o_msi_hart), 0);
      tick();

      // Table-driven single writes, consumer always ready
      i_msi_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wr(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].push, vecs[i].e);
         @(negedge i_clk);
         check("vec_valid", 32'(o_msi_valid), 32'(vecs[i].push));
         check("vec_level", 32'(o_fifo_level), 32'(vecs[i].push));
         check("vec_drop",  32'(o_drop_cnt), 32'(exp_drop));
         tick();
      end
      repeat (3) tick();
      check("tbl_sb_empty", 32'(sb_q.size()), 0);

      // Fill to full with the consumer stalled, then release one slot
      i_msi_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr(MB + 32'(i) * 32'h1000, 32'(21 + i), 4'hF, 1'b1, mk(i, 0, 21 + i));
      end
      fork
         wr(SB + 32'h1000, 32'd25, 4'hF, 1'b1, mk(0, 2, 25));
         begin
            @(negedge i_clk);
            check("full_ready", 32'(o_wr_ready), 0);
            check("full_level", 32'(o_fifo_level), 4);
            @(posedge i_clk);
            #1;
            i_msi_ready = 1'b1;
            @(negedge i_clk);
            check("full_pop_ready", 32'(o_wr_ready), 0);
            @(posedge i_clk);
            #1;
            i_msi_ready = 1'b0;
            @(negedge i_clk);
            check("after_pop_ready", 32'(o_wr_ready), 1);
            check("after_pop_level", 32'(o_fifo_level), 3);
            @(posedge i_clk);
            #1;
            @(negedge i_clk);
            check("refill_level", 32'(o_fifo_level), 4);
         end
      join
      tick();
      i_msi_ready = 1'b1;
      repeat (6) tick();
      check("full_drain_level", 32'(o_fifo_level), 0);
      check("full_sb_empty", 32'(sb_q.size()), 0);

      // Simultaneous push and pop at level 2, wrapping the pointers
      i_msi_ready = 1'b0;
      wr(MB,           32'd40, 4'hF, 1'b1, mk(0, 0, 40));
      wr(MB + 32'h1000, 32'd41, 4'hF, 1'b1, mk(1, 0, 41));
      for (int k = 0; k < 8; k++) begin
         i_msi_ready = 1'b1;
         i_wr_valid  = 1'b1;
         i_wr_addr   = MB + 32'(k % 4) * 32'h1000;
         i_wr_data   = 32'(50 + k);
         i_wr_be     = 4'hF;
         @(negedge i_clk);
         check("pp_level", 32'(o_fifo_level), 2);
         check("pp_ready", 32'(o_wr_ready), 1);
         if (o_wr_ready) sb_q.push_back(mk(k % 4, 0, 50 + k));
         tick();
      end
      i_wr_valid = 1'b0;
      repeat (4) tick();
      check("pp_drain_level", 32'(o_fifo_level), 0);
      check("pp_sb_empty", 32'(sb_q.size()), 0);

      // Reset with three entries queued flushes everything
      i_msi_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr(SB + 32'(i) * 32'h1000, 32'(60 + i), 4'hF, 1'b1, mk(i / 2, (i % 2) + 1, 60 + i));
      end
      @(negedge i_clk);
      check("pre_rst_level", 32'(o_fifo_level), 3);
      check("pre_rst_drop",  32'(o_drop_cnt), 32'(exp_drop));
      tick();
      i_rst = 1'b1;
      @(negedge i_clk);
      check("mid_rst_ready", 32'(o_wr_ready), 0);
      tick();
      i_rst = 1'b0;
      exp_drop = 0;
      @(negedge i_clk);
      check("post_rst_valid", 32'(o_msi_valid), 0);
      check("post_rst_level", 32'(o_fifo_level), 0);
      check("post_rst_drop",  32'(o_drop_cnt), 0);
      check("post_rst_ready", 32'(o_wr_ready), 1);
      pops_before = pops;
      tick();
      i_msi_ready = 1'b1;
      wr(MB + 32'h2000, 32'd77, 4'hF, 1'b1, mk(2, 0, 77));
      repeat (5) tick();
      check("post_rst_pops",  32'(pops - pops_before), 1);
      check("post_rst_final_level", 32'(o_fifo_level), 0);
      check("post_rst_sb_empty", 32'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
